snake_mover: RTL and testbench

//  Snake body engine, downstream of the game state machine. On each move strobe (MOVE state) it

---
 rtl/snake_pkg.sv | 36 +++
 rtl/snake_body_buf.sv | 55 +++++
 rtl/snake_mover.sv | 213 +++++++++++++++++++++
 tb/tb_snake_mover.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// snake_pkg
// Shared definitions for the snake game slice.
//   DIR_UP/DIR_DOWN/DIR_LEFT/DIR_RIGHT : 2-bit heading codes
//   state_t                            : step engine FSM states
//   coord_t                            : {x,y} cell coordinate used by the food
//                                        generator and renderer at the default width
//   dir_opposite()                     : true when two headings point opposite ways
package snake_pkg;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  localparam int SNAKE_COORD_W = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_SCAN,
    ST_COMMIT,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [SNAKE_COORD_W-1:0] x;
    logic [SNAKE_COORD_W-1:0] y;
  } coord_t;

  // Up/down share bit 1 = 0 and left/right share bit 1 = 1; within a pair
  // the two directions differ only in bit 0.
  function automatic logic dir_opposite(input logic [1:0] a, input logic [1:0] b);
    return (a[1] == b[1]) && (a[0] != b[0]);
  endfunction

endpackage

// File: rtl/snake_body_buf.sv
// snake_body_buf
// Body segment storage: MAX_LEN entries of {x,y}, one synchronous write port and
// two combinational read ports (one for the collision scan, one for the renderer).
// Reset loads the initial horizontal body into slots 0..INIT_LEN-1 so that the
// engine can start with head_ptr = 0.
//   clk, RST              : clock, synchronous active-high reset
//   we, wr_addr, wr_x/y   : write port
//   scan_addr, scan_x/y   : scan read port
//   rd_addr, rd_x/y       : renderer read port
module snake_body_buf
  import snake_pkg::*;
#(
  parameter int GRID_W   = 40,
  parameter int GRID_H   = 30,
  parameter int COORD_W  = 6,
  parameter int MAX_LEN  = 64,
  parameter int IDX_W    = 6,
  parameter int INIT_LEN = 3
) (
  input  logic               clk,
  input  logic               RST,
  input  logic               we,
  input  logic [IDX_W-1:0]   wr_addr,
  input  logic [COORD_W-1:0] wr_x,
  input  logic [COORD_W-1:0] wr_y,
  input  logic [IDX_W-1:0]   scan_addr,
  output logic [COORD_W-1:0] scan_x,
  output logic [COORD_W-1:0] scan_y,
  input  logic [IDX_W-1:0]   rd_addr,
  output logic [COORD_W-1:0] rd_x,
  output logic [COORD_W-1:0] rd_y
);

  logic [COORD_W-1:0] mem_x [MAX_LEN];
  logic [COORD_W-1:0] mem_y [MAX_LEN];

  // Reset lays the body out leftwards from the grid centre; unused slots are zeroed.
  always_ff @(posedge clk) begin
    if (RST) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        mem_x[i] <= (i < INIT_LEN) ? COORD_W'(GRID_W / 2 - i) : '0;
        mem_y[i] <= (i < INIT_LEN) ? COORD_W'(GRID_H / 2) : '0;
      end
    end else if (we) begin
      mem_x[wr_addr] <= wr_x;
      mem_y[wr_addr] <= wr_y;
    end
  end

  assign scan_x = mem_x[scan_addr];
  assign scan_y = mem_y[scan_addr];
  assign rd_x   = mem_x[rd_addr];
  assign rd_y   = mem_y[rd_addr];

endmodule

// File: rtl/snake_mover.sv
// snake_mover
// Snake body engine. Each honoured move strobe computes the new head from the
// heading, checks walls and self-collision, then commits the step and grows the
// body when food is eaten.
//   clk, RST            : clock, synchronous active-high reset
//   move, dir           : step request and requested heading
//   food_x/y, food_valid: food position (sampled in CALC only)
//   rd_idx, rd_x/y,     : renderer read port, segment 0 = head
//   rd_valid
//   busy, done, ate     : step status; done/ate are one-cycle pulses
//   dead, score, length : game state
// Optional feature: define WRAP_WALLS_EN to make the walls wrap instead of kill.
module snake_mover
  import snake_pkg::*;
#(
  parameter int GRID_W   = 40,
  parameter int GRID_H   = 30,
  parameter int COORD_W  = 6,
  parameter int MAX_LEN  = 64,
  parameter int IDX_W    = 6,
  parameter int INIT_LEN = 3
) (
  input  logic               clk,
  input  logic               RST,
  input  logic               move,
  input  logic [1:0]         dir,
  input  logic [COORD_W-1:0] food_x,
  input  logic [COORD_W-1:0] food_y,
  input  logic               food_valid,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [COORD_W-1:0] rd_x,
  output logic [COORD_W-1:0] rd_y,
  output logic               rd_valid,
  output logic               busy,
  output logic               done,
  output logic               ate,
  output logic               dead,
  output logic [7:0]         score,
  output logic [IDX_W:0]     length
);

  localparam logic [IDX_W:0]          LEN_MAX  = (IDX_W + 1)'(MAX_LEN);
  localparam logic [IDX_W:0]          LEN_INIT = (IDX_W + 1)'(INIT_LEN);
  localparam logic [IDX_W:0]          LEN_ONE  = (IDX_W + 1)'(1);
  localparam logic [IDX_W-1:0]        PTR_ONE  = IDX_W'(1);
  localparam logic signed [COORD_W:0] W_S      = (COORD_W + 1)'(GRID_W);
  localparam logic signed [COORD_W:0] H_S      = (COORD_W + 1)'(GRID_H);
  localparam logic signed [COORD_W:0] S_ONE    = (COORD_W + 1)'(1);

  state_t             state;
  logic [1:0]         heading;
  logic [IDX_W-1:0]   head_ptr;
  logic [COORD_W-1:0] nh_x;
  logic [COORD_W-1:0] nh_y;
  logic               grow;
  logic               food_hit;
  logic               ate_flag;
  logic [IDX_W:0]     scan_k;
  logic [IDX_W:0]     scan_n;

  logic [IDX_W-1:0]   scan_addr;
  logic [IDX_W-1:0]   rd_addr;
  logic [COORD_W-1:0] seg_x;
  logic [COORD_W-1:0] seg_y;

  logic [1:0]               eff_dir;
  logic signed [COORD_W:0]  cx;
  logic signed [COORD_W:0]  cy;
  logic [COORD_W-1:0]       nx;
  logic [COORD_W-1:0]       ny;
  logic                     off_grid;
  logic                     food_match;
  logic                     can_grow;

  // scan_k is held at 0 through CALC, so the scan port then reads the current head.
  assign scan_addr = head_ptr + scan_k[IDX_W-1:0];
  assign rd_addr   = head_ptr + rd_idx;
  assign rd_valid  = {1'b0, rd_idx} < length;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign ate       = (state == ST_DONE) && ate_flag;

  snake_body_buf #(
    .GRID_W   (GRID_W),
    .GRID_H   (GRID_H),
    .COORD_W  (COORD_W),
    .MAX_LEN  (MAX_LEN),
    .IDX_W    (IDX_W),
    .INIT_LEN (INIT_LEN)
  ) u_body (
    .clk       (clk),
    .RST       (RST),
    .we        (state == ST_COMMIT),
    .wr_addr   (head_ptr - PTR_ONE),
    .wr_x      (nh_x),
    .wr_y      (nh_y),
    .scan_addr (scan_addr),
    .scan_x    (seg_x),
    .scan_y    (seg_y),
    .rd_addr   (rd_addr),
    .rd_x      (rd_x),
    .rd_y      (rd_y)
  );

  // New-head computation used in CALC. Coordinates are widened by one signed bit
  // so that stepping off either edge is visible as negative or >= grid size.
  always_comb begin
    eff_dir = dir_opposite(dir, heading) ? heading : dir;
    cx = $signed({1'b0, seg_x});
    cy = $signed({1'b0, seg_y});
    case (eff_dir)
      DIR_UP:    cy = cy - S_ONE;
      DIR_DOWN:  cy = cy + S_ONE;
      DIR_LEFT:  cx = cx - S_ONE;
      default:   cx = cx + S_ONE;
    endcase
    nx = cx[COORD_W-1:0];
    ny = cy[COORD_W-1:0];
`ifdef WRAP_WALLS_EN
    off_grid = 1'b0;
    if (cx[COORD_W]) begin
      nx = COORD_W'(GRID_W - 1);
    end else if (cx >= W_S) begin
      nx = '0;
    end
    if (cy[COORD_W]) begin
      ny = COORD_W'(GRID_H - 1);
    end else if (cy >= H_S) begin
      ny = '0;
    end
`else
    off_grid = cx[COORD_W] || cy[COORD_W] || (cx >= W_S) || (cy >= H_S);
`endif
    food_match = food_valid && (nx == food_x) && (ny == food_y);
    can_grow   = food_match && (length < LEN_MAX);
  end

  // Step FSM. Nothing visible changes before COMMIT, so a reset or a collision
  // anywhere earlier leaves the body untouched.
  always_ff @(posedge clk) begin
    if (RST) begin
      state    <= ST_IDLE;
      heading  <= DIR_RIGHT;
      head_ptr <= '0;
      length   <= LEN_INIT;
      nh_x     <= '0;
      nh_y     <= '0;
      grow     <= 1'b0;
      food_hit <= 1'b0;
      ate_flag <= 1'b0;
      scan_k   <= '0;
      scan_n   <= '0;
      dead     <= 1'b0;
      score    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (move && !dead) begin
            state    <= ST_CALC;
            scan_k   <= '0;
            ate_flag <= 1'b0;
          end
        end
        ST_CALC: begin
          heading  <= eff_dir;
          nh_x     <= nx;
          nh_y     <= ny;
          food_hit <= food_match;
          grow     <= can_grow;
          // The tail vacates this step unless the snake grows, so it is not scanned.
          scan_n   <= can_grow ? length : (length - LEN_ONE);
          if (off_grid) begin
            dead  <= 1'b1;
            state <= ST_DONE;
          end else begin
            state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if ((seg_x == nh_x) && (seg_y == nh_y)) begin
            dead  <= 1'b1;
            state <= ST_DONE;
          end else if (scan_k == (scan_n - LEN_ONE)) begin
            state <= ST_COMMIT;
          end else begin
            scan_k <= scan_k + LEN_ONE;
          end
        end
        ST_COMMIT: begin
          head_ptr <= head_ptr - PTR_ONE;
          if (grow) begin
            length <= length + LEN_ONE;
          end
          // Eating still scores when the buffer is full; only growth is capped.
          if (food_hit) begin
            ate_flag <= 1'b1;
            if (score != 8'hFF) begin
              score <= score + 8'd1;
            end
          end
          state <= ST_DONE;
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snake_mover.sv
// tb_snake_mover
// Self-checking bench for snake_mover. A queue-based reference snake predicts the
// body, score, death and step latency; directed scenarios are followed by a
// saturation run around a closed loop and randomized games.
// The DUT uses a 16-entry body buffer so that the full-buffer case is reachable.
module tb_snake_mover;

  localparam int GW    = 40;
  localparam int GH    = 30;
  localparam int CW    = 6;
  localparam int MAXL  = 16;
  localparam int IW    = 4;

  logic          clk;
  logic          RST;
  logic          move;
  logic [1:0]    dir;
  logic [CW-1:0] food_x;
  logic [CW-1:0] food_y;
  logic          food_valid;
  logic [IW-1:0] rd_idx;
  logic [CW-1:0] rd_x;
  logic [CW-1:0] rd_y;
  logic          rd_valid;
  logic          busy;
  logic          done;
  logic          ate;
  logic          dead;
  logic [7:0]    score;
  logic [IW:0]   length;

  int nChecks = 0;
  int nErrors = 0;

  // reference snake: index 0 is the head
  int mx[$];
  int my[$];
  int mHeading;
  int mScore;
  bit mDead;

  snake_mover #(
    .GRID_W   (GW),
    .GRID_H   (GH),
    .COORD_W  (CW),
    .MAX_LEN  (MAXL),
    .IDX_W    (IW),
    .INIT_LEN (3)
  ) dut (
    .clk        (clk),
    .RST        (RST),
    .move       (move),
    .dir        (dir),
    .food_x     (food_x),
    .food_y     (food_y),
    .food_valid (food_valid),
    .rd_idx     (rd_idx),
    .rd_x       (rd_x),
    .rd_y       (rd_y),
    .rd_valid   (rd_valid),
    .busy       (busy),
    .done       (done),
    .ate        (ate),
    .dead       (dead),
    .score      (score),
    .length     (length)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nChecks++;
    if (observed !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic bit isReverse(input int a, input int b);
    return (a == 0 && b == 1) || (a == 1 && b == 0) || (a == 2 && b == 3) || (a == 3 && b == 2);
  endfunction

  task automatic modelReset();
    mx.delete();
    my.delete();
    for (int i = 0; i < 3; i++) begin
      mx.push_back(GW / 2 - i);
      my.push_back(GH / 2);
    end
    mHeading = 3;
    mScore   = 0;
    mDead    = 1'b0;
  endtask

  // Where the head would go for requested heading d (heading itself not updated).
  task automatic modelNext(input int d, output int nx, output int ny, output int eff, output bit off);
    eff = isReverse(d, mHeading) ? mHeading : d;
    nx = mx[0];
    ny = my[0];
    case (eff)
      0: ny = ny - 1;
      1: ny = ny + 1;
      2: nx = nx - 1;
      default: nx = nx + 1;
    endcase
    off = (nx < 0) || (nx >= GW) || (ny < 0) || (ny >= GH);
`ifdef WRAP_WALLS_EN
    nx  = (nx + GW) % GW;
    ny  = (ny + GH) % GH;
    off = 1'b0;
`endif
  endtask

  task automatic modelStep(input int d, input bit fv, input int fx, input int fy,
                           output int expLat, output bit expAte);
    int nx, ny, eff, n;
    bit off, foodHit, grow;
    modelNext(d, nx, ny, eff, off);
    mHeading = eff;
    expAte = 1'b0;
    if (off) begin
      mDead  = 1'b1;
      expLat = 2;
      return;
    end
    foodHit = fv && (nx == fx) && (ny == fy);
    grow    = foodHit && (mx.size() < MAXL);
    n       = grow ? mx.size() : mx.size() - 1;
    for (int k = 0; k < n; k++) begin
      if (mx[k] == nx && my[k] == ny) begin
        mDead  = 1'b1;
        expLat = k + 3;
        return;
      end
    end
    mx.push_front(nx);
    my.push_front(ny);
    if (!grow) begin
      void'(mx.pop_back());
      void'(my.pop_back());
    end
    if (foodHit && mScore < 255) mScore++;
    expAte = foodHit;
    expLat = n + 3;
  endtask

  // Compares the whole visible state against the reference snake.
  task automatic checkState(input string tag);
    checkOutput({tag, ".dead"}, dead, mDead);
    checkOutput({tag, ".score"}, score, mScore);
    checkOutput({tag, ".length"}, length, mx.size());
    checkOutput({tag, ".busy"}, busy, 0);
    for (int i = 0; i < mx.size(); i++) begin
      rd_idx = IW'(i);
      #1;
      checkOutput($sformatf("%s.seg%0d.x", tag, i), rd_x, mx[i]);
      checkOutput($sformatf("%s.seg%0d.y", tag, i), rd_y, my[i]);
    end
    checkOutput({tag, ".rdValidLast"}, rd_valid, 1);
    if (mx.size() < MAXL) begin
      rd_idx = IW'(mx.size());
      #1;
      checkOutput({tag, ".rdValidPastEnd"}, rd_valid, 0);
    end
  endtask

  task automatic applyReset();
    @(posedge clk);
    #1;
    RST = 1'b1;
    move = 1'b0;
    food_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    RST = 1'b0;
    modelReset();
    @(negedge clk);
    checkOutput("reset.done", done, 0);
    checkOutput("reset.ate", ate, 0);
    checkState("reset");
  endtask

  // One move request; checks latency, ate pulse, ignored extra moves and resulting state.
  task automatic applyStimulus(input int d, input bit fv, input int fx, input int fy,
                               input bit injectBusy, output int lat);
    int expLat, cnt;
    bit expAte, sawDone, sawAte, stray;
    lat = 0;
    sawAte = 1'b0;
    sawDone = 1'b0;
    if (mDead) begin
      @(posedge clk);
      #1;
      dir = 2'(d);
      move = 1'b1;
      @(posedge clk);
      #1;
      move = 1'b0;
      repeat (6) begin
        @(negedge clk);
        if (done || busy) sawDone = 1'b1;
      end
      checkOutput("deadMoveIgnored", sawDone, 0);
      checkState("afterDeadMove");
      return;
    end
    modelStep(d, fv, fx, fy, expLat, expAte);
    @(posedge clk);
    #1;
    dir = 2'(d);
    move = 1'b1;
    food_valid = fv;
    food_x = CW'(fx);
    food_y = CW'(fy);
    cnt = 0;
    while (!sawDone && cnt < 100) begin
      @(posedge clk);
      cnt++;
      #1;
      if (cnt == 1) move = 1'b0;
      if (cnt == 2) begin
        // food has been sampled by now; later values must not matter
        food_valid = 1'($urandom);
        food_x = CW'($urandom_range(0, GW - 1));
        food_y = CW'($urandom_range(0, GH - 1));
        if (injectBusy) move = 1'b1;
      end
      if (cnt == 3) move = 1'b0;
      @(negedge clk);
      if (cnt == 1) checkOutput("busyInCalc", busy, 1);
      if (done) begin
        sawDone = 1'b1;
        sawAte = ate;
      end
    end
    lat = cnt;
    checkOutput("doneSeen", sawDone, 1);
    checkOutput("doneLatency", cnt, expLat);
    checkOutput("atePulse", sawAte, expAte);
    // a move coincident with the done pulse must be dropped
    move = 1'b1;
    @(posedge clk);
    #1;
    move = 1'b0;
    stray = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done || busy || ate) stray = 1'b1;
    end
    checkOutput("noStrayStep", stray, 0);
    checkState("step");
  endtask

  // Reset asserted while the collision scan is running.
  task automatic resetDuringScan();
    bit sawDone;
    sawDone = 1'b0;
    @(posedge clk);
    #1;
    dir = 2'(mHeading);
    move = 1'b1;
    food_valid = 1'b0;
    @(posedge clk);
    #1;
    move = 1'b0;
    @(posedge clk);
    #1;
    RST = 1'b1;
    @(negedge clk);
    checkOutput("abort.busyInScan", busy, 1);
    if (done) sawDone = 1'b1;
    @(posedge clk);
    #1;
    RST = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done) sawDone = 1'b1;
    end
    checkOutput("abort.noDone", sawDone, 0);
    modelReset();
    checkState("abort");
  endtask

  function automatic int loopDir(input int s);
    int p;
    p = s % 20;
    if (p < 6) return 3;
    if (p < 10) return 1;
    if (p < 16) return 2;
    return 0;
  endfunction

  initial begin
    int lat, nx, ny, eff, d, fx, fy, r;
    bit off, fv;
    RST = 1'b1;
    move = 1'b0;
    dir = 2'b11;
    food_x = '0;
    food_y = '0;
    food_valid = 1'b0;
    rd_idx = '0;
    $display("[TB] start");

    // step right, no food
    applyReset();
    applyStimulus(3, 0, 0, 0, 0, lat);
    checkOutput("t1.latency", lat, 5);
    rd_idx = '0;
    #1;
    checkOutput("t1.headX", rd_x, 21);
    checkOutput("t1.headY", rd_y, 15);
    checkOutput("t1.length", length, 3);
    checkOutput("t1.score", score, 0);

    // reverse request ignored
    applyReset();
    applyStimulus(2, 0, 0, 0, 1, lat);
    rd_idx = '0;
    #1;
    checkOutput("t2.headX", rd_x, 21);
    checkOutput("t2.headY", rd_y, 15);

    // eat food straight ahead
    applyReset();
    applyStimulus(3, 1, 21, 15, 0, lat);
    checkOutput("t3.length", length, 4);
    checkOutput("t3.score", score, 1);
    rd_idx = IW'(3);
    #1;
    checkOutput("t3.seg3X", rd_x, 18);
    checkOutput("t3.seg3Y", rd_y, 15);

    // reset in the middle of a scan
    resetDuringScan();
    checkOutput("t6.length", length, 3);
    checkOutput("t6.score", score, 0);

    // run into the right wall
    applyReset();
    for (int i = 0; i < 19; i++) applyStimulus(3, 0, 0, 0, i[0], lat);
    rd_idx = '0;
    #1;
    checkOutput("t4.preX", rd_x, 39);
    applyStimulus(3, 0, 0, 0, 0, lat);
    rd_idx = '0;
    #1;
`ifdef WRAP_WALLS_EN
    checkOutput("t4.wrapX", rd_x, 0);
    checkOutput("t4.wrapY", rd_y, 15);
    checkOutput("t4.dead", dead, 0);
`else
    checkOutput("t4.latency", lat, 2);
    checkOutput("t4.dead", dead, 1);
    checkOutput("t4.headX", rd_x, 39);
    applyStimulus(0, 0, 0, 0, 0, lat);
    applyStimulus(1, 0, 0, 0, 0, lat);
`endif

    // turn into the vacating tail is legal
    applyReset();
    applyStimulus(3, 1, 21, 15, 0, lat);
    applyStimulus(0, 0, 0, 0, 0, lat);
    applyStimulus(2, 0, 0, 0, 0, lat);
    applyStimulus(1, 0, 0, 0, 0, lat);
    checkOutput("t5.tailDead", dead, 0);
    checkOutput("t5.tailLatency", lat, 6);

    // U-shaped body, turn into segment 3
    applyReset();
    applyStimulus(3, 1, 21, 15, 0, lat);
    applyStimulus(3, 1, 22, 15, 0, lat);
    applyStimulus(0, 0, 0, 0, 0, lat);
    applyStimulus(2, 0, 0, 0, 0, lat);
    applyStimulus(1, 0, 0, 0, 0, lat);
    checkOutput("t5.selfDead", dead, 1);
    checkOutput("t5.selfLatency", lat, 6);
    checkOutput("t5.length", length, 5);

    // circle a 20-cell loop eating every step: fills the buffer and saturates score
    applyReset();
    for (int s = 0; s < 270; s++) begin
      d = loopDir(s);
      modelNext(d, nx, ny, eff, off);
      applyStimulus(d, 1, nx, ny, 0, lat);
    end
    checkOutput("sat.score", score, 255);
    checkOutput("sat.length", length, MAXL);
    checkOutput("sat.dead", dead, 0);

    // randomized games
    applyReset();
    for (int s = 0; s < 220; s++) begin
      d = int'($urandom_range(0, 3));
      r = int'($urandom_range(0, 9));
      modelNext(d, nx, ny, eff, off);
      if (r < 5) begin
        fv = 1'b1;
        fx = nx & 63;
        fy = ny & 63;
      end else begin
        fv = (r < 7);
        fx = int'($urandom_range(0, GW - 1));
        fy = int'($urandom_range(0, GH - 1));
      end
      applyStimulus(d, fv, fx, fy, 1'($urandom), lat);
      if (mDead) begin
        applyStimulus(int'($urandom_range(0, 3)), 0, 0, 0, 0, lat);
        applyReset();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
